// File: rtl/uart_pkg.sv
// Shared UART definitions: statistics width, parity modes,
// and FIFO pointer sizing used across the receive/transmit path.
package uart_pkg;

   localparam int STAT_CNT_WIDTH = 16;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_ODD  = 2'd1,
      PARITY_EVEN = 2'd2
   } parity_e;

   // Extra MSB separates full from empty with equal indices
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a same-cycle clear beats an increment.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] cnt
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with first-word fall-through AXI-Stream output.
// Define UART_RX_FIFO_STATS_EN to build the overflow/parity counters.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int DEPTH           = 16,
   parameter bit DROP_PARITY_ERR = 1'b1
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic                       s_axis_tvalid,
   input  logic                       s_axis_tuser,
   output logic                       s_axis_tready,
   output logic [DATA_WIDTH-1:0]      m_axis_tdata,
   output logic                       m_axis_tuser,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic [STAT_CNT_WIDTH-1:0]  overflow_cnt,
   output logic [STAT_CNT_WIDTH-1:0]  parity_err_cnt,
   input  logic                       cnt_clr
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH:0] mem_q [DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic                rdy_q;
   logic [DATA_WIDTH:0] head;
   logic                empty, full;
   logic                wr_req, rd_en, wr_en, ovf_inc;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign wr_req  = s_axis_tvalid &&
                    !(DROP_PARITY_ERR && s_axis_tuser);
   assign rd_en   = m_axis_tvalid && m_axis_tready;
   // A full FIFO only takes a word when the head leaves this cycle
   assign wr_en   = wr_req && (!full || rd_en);
   assign ovf_inc = wr_req && full && !rd_en;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         rdy_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         rdy_q    <= 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tuser, s_axis_tdata};
      end
   end

   assign head          = mem_q[rd_ptr_q[AW-1:0]];
   assign m_axis_tvalid = !empty;
   assign m_axis_tdata  = empty ? '0 : head[DATA_WIDTH-1:0];
   assign m_axis_tuser  = !empty && head[DATA_WIDTH];
   assign fill_level    = wr_ptr_q - rd_ptr_q;
   assign s_axis_tready = rdy_q;

`ifdef UART_RX_FIFO_STATS_EN
   logic par_inc;

   assign par_inc = s_axis_tvalid && s_axis_tuser;

   sat_counter #(.WIDTH(STAT_CNT_WIDTH)) u_ovf_cnt (
      .clk   (aclk),
      .rst_n (aresetn),
      .inc   (ovf_inc),
      .clr   (cnt_clr),
      .cnt   (overflow_cnt)
   );

   sat_counter #(.WIDTH(STAT_CNT_WIDTH)) u_par_cnt (
      .clk   (aclk),
      .rst_n (aresetn),
      .inc   (par_inc),
      .clr   (cnt_clr),
      .cnt   (parity_err_cnt)
   );
`else
   logic unused_stats;

   assign unused_stats   = cnt_clr ^ ovf_inc;
   assign overflow_cnt   = '0;
   assign parity_err_cnt = '0;
`endif

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer sitting directly downstream of the UART receiver's AXI-Stream master. The receiver emits one-cycle tvalid pulses and ignores tready, so this block accepts every beat unconditionally. It buffers words in a circular FIFO, optionally discards parity-errored words, and presents a standard back-pressurable AXI-Stream master to the system. It also keeps saturating overflow and parity-error statistics.

Parameters:
DATA_WIDTH, 8, word width; matches the receiver's BIT_PER_WORD.
DEPTH, 16, FIFO entries; power of two, at least 2.
DROP_PARITY_ERR, 1, 1 = words with tuser=1 are discarded; 0 = they are stored and tuser is forwarded.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous, active-low reset
s_axis_tdata  in  DATA_WIDTH  received word
s_axis_tvalid  in  1  one-cycle pulse per received word
s_axis_tuser  in  1  parity error flag of the word
s_axis_tready  out  1  constant 1 out of reset, 0 in reset; informational only
m_axis_tdata  out  DATA_WIDTH  head-of-FIFO word
m_axis_tuser  out  1  parity flag of head word; always 0 when DROP_PARITY_ERR=1
m_axis_tvalid  out  1  FIFO not empty
m_axis_tready  in  1  downstream accept
fill_level  out  $clog2(DEPTH)+1  number of stored words, 0..DEPTH
overflow_cnt  out  16  words lost because the FIFO was full
parity_err_cnt  out  16  words received with tuser=1
cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Clock and reset: single clock aclk; aresetn is asynchronous, active-low.
- Reset (async assert, sync use after deassert):
  - wr_ptr, rd_ptr and fill_level are 0.
  - m_axis_tvalid and m_axis_tuser are 0; m_axis_tdata is 0.
  - Both counters are 0.
  - Storage contents are don't-care.
- Reset mid-operation: all stored words are lost; m_axis_tvalid drops immediately (combinational from the pointers).
- Storage: DEPTH × (DATA_WIDTH+1) array holding {tuser, tdata}.
  - Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty; indices wrap naturally.
- Write qualification: wr_req = s_axis_tvalid && !(DROP_PARITY_ERR && s_axis_tuser).
- Read: rd_en = m_axis_tvalid && m_axis_tready.
- Write is accepted when wr_req && (!full || rd_en).
  - Full with a simultaneous read: both occur and fill_level stays DEPTH.
- Write when full without a read: the word is discarded, overflow_cnt increments, and the pointers are unchanged.
- Output timing:
  - First-word fall-through: m_axis_tdata/m_axis_tuser are combinational from array[rd_ptr] and m_axis_tvalid = !empty.
  - A word written in cycle N is valid at the output in cycle N+1.
- AXIS rule: once m_axis_tvalid is high, the head word stays stable until it is accepted (the head entry is never overwritten, because a write into a full FIFO is only allowed on a concurrent read).
- Empty FIFO with a simultaneous write: no read occurs; m_axis_tvalid rises next cycle.
- fill_level = wr_ptr - rd_ptr, updated every cycle (+1 on write only, -1 on read only, unchanged on both or neither).
- parity_err_cnt increments on every s_axis_tvalid && s_axis_tuser, whether or not the word is dropped or overflows.
- Counters:
  - Both are 16-bit and saturate at 0xFFFF.
  - cnt_clr has priority over a same-cycle increment: the result is 0.

Optional Feature:
- Macro UART_RX_FIFO_STATS_EN.
- Defined: overflow_cnt and parity_err_cnt behave as above.
- Undefined:
  - Counter logic is not generated; both ports are tied to 16'h0000.
  - cnt_clr is ignored.
  - Data-path behaviour (drop, overflow discard) is identical.

Decomposition:
- Shared package uart_pkg:
  - STAT_CNT_WIDTH = 16.
  - Parity-mode enum PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2, also used by the receiver and transmitter.
  - Function ptr_width(depth) returning $clog2(depth)+1.
- One sub-module, sat_counter (parameter WIDTH; inputs inc, clr; output cnt):
  - Saturating, clear-priority counter.
  - Instantiated twice under UART_RX_FIFO_STATS_EN.

Test Plan:
1. Reset then a single pulse with tdata=0xA5, tuser=0, m_axis_tready=1 -> m_axis_tvalid high exactly one cycle later with tdata=0xA5; fill_level 0->1->0.
2. m_axis_tready=0, write 20 words 0x00..0x13 with DEPTH=16 -> fill_level=16, overflow_cnt=4; then drain -> outputs exactly 0x00..0x0F in order.
3. DROP_PARITY_ERR=1, write 0x11 (tuser=0), 0x22 (tuser=1), 0x33 (tuser=0) -> output 0x11, 0x33 only; parity_err_cnt=1. With DROP_PARITY_ERR=0 -> all three words output, 0x22 with m_axis_tuser=1.
4. FIFO full (16 words), m_axis_tready=1 in the same cycle as a write of 0x7E -> head popped, 0x7E stored, fill_level stays 16, overflow_cnt unchanged.
5. Assert cnt_clr in the same cycle as an overflow with overflow_cnt=5 -> overflow_cnt=0 next cycle. Force 0xFFFF overflows -> counter holds 0xFFFF.
6. Assert aresetn low asynchronously (between clock edges) while fill_level=7 and tvalid=1 -> m_axis_tvalid and fill_level go to 0 without a clock edge; after release, the first new write outputs correctly.
